// File: rtl/potential_decay_pkg.sv
// Shared constants for the potential_decay / potential_adder pipeline:
// model codes, FSM state encodings and the reset decay configuration.
package potential_decay_pkg;

    localparam logic [1:0] MODEL_LIF  = 2'b00;
    localparam logic [1:0] MODEL_IZH  = 2'b01;
    localparam logic [1:0] MODEL_QLIF = 2'b10;
    localparam logic [1:0] MODEL_RSVD = 2'b11;

    localparam logic [7:0] DEFAULT_CFG = 8'h12;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Izhikevich and the reserved code pass the potential through untouched.
    function automatic logic is_bypass(input logic [1:0] model);
        return (model == MODEL_IZH) || (model == MODEL_RSVD);
    endfunction

endpackage

// File: rtl/potential_decay_shifter.sv
// Arithmetic right shifter used for the decay terms (V >>> term+1).
module potential_decay_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 3
) (
    input  logic signed [DATA_WIDTH-1:0] data,
    input  logic        [SHAMT_W-1:0]    shamt,
    output logic signed [DATA_WIDTH-1:0] shifted
);

    assign shifted = data >>> shamt;

endmodule

// File: rtl/potential_decay.sv
// Membrane potential leak: iterative shift-and-subtract, one term per cycle.
// Optional macro DECAY_LEAK_FLOOR_EN forces small non-bypass results to zero.
module potential_decay #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         NUM_TERMS   = 4,
    parameter logic [7:0] DEFAULT_CFG = potential_decay_pkg::DEFAULT_CFG,
    parameter int         LEAK_FLOOR  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         time_step,
    input  logic signed [DATA_WIDTH-1:0] potential_in,
    input  logic        [1:0]            model,
    input  logic                         load,
    input  logic        [7:0]            decay_cfg,
    output logic signed [DATA_WIDTH-1:0] decayed_potential,
    output logic                         done,
    output logic                         busy
);

    import potential_decay_pkg::*;

    localparam int TERM_W  = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam int SHAMT_W = $clog2(NUM_TERMS + 1);
    localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(NUM_TERMS - 1);
    localparam logic signed [DATA_WIDTH-1:0] FLOOR_POS = DATA_WIDTH'(LEAK_FLOOR);
    localparam logic signed [DATA_WIDTH-1:0] FLOOR_NEG = -FLOOR_POS;
`ifdef DECAY_LEAK_FLOOR_EN
    localparam logic FLOOR_EN = 1'b1;
`else
    localparam logic FLOOR_EN = 1'b0;
`endif

    state_t                         state_r;
    logic        [7:0]              cfg_r;
    logic signed [DATA_WIDTH-1:0]   v_r;
    logic signed [DATA_WIDTH-1:0]   acc_r;
    logic        [NUM_TERMS-1:0]    mask_r;
    logic        [TERM_W-1:0]       term_r;
    logic        [SHAMT_W-1:0]      shamt_s;
    logic signed [DATA_WIDTH-1:0]   term_s;
    logic signed [DATA_WIDTH-1:0]   acc_next_s;
    logic signed [DATA_WIDTH-1:0]   result_s;

    assign shamt_s = SHAMT_W'(term_r) + SHAMT_W'(1);

    potential_decay_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_W    (SHAMT_W)
    ) u_shifter (
        .data    (v_r),
        .shamt   (shamt_s),
        .shifted (term_s)
    );

    // Next accumulator value and the (optionally floored) final result.
    always_comb begin
        acc_next_s = acc_r;
        result_s   = acc_r;
        if (mask_r[term_r]) begin
            acc_next_s = acc_r - term_s;
        end else begin
            acc_next_s = acc_r;
        end
        if (FLOOR_EN && (acc_next_s > FLOOR_NEG) && (acc_next_s < FLOOR_POS)) begin
            result_s = '0;
        end else begin
            result_s = acc_next_s;
        end
    end

    // Decay configuration register; in-flight ops keep their own mask snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_r <= DEFAULT_CFG;
        end else if (load) begin
            cfg_r <= decay_cfg;
        end else begin
            cfg_r <= cfg_r;
        end
    end

    // Control FSM, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r           <= IDLE;
            v_r               <= '0;
            acc_r             <= '0;
            mask_r            <= '0;
            term_r            <= '0;
            decayed_potential <= '0;
            done              <= 1'b0;
            busy              <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (time_step) begin
                        v_r    <= potential_in;
                        acc_r  <= potential_in;
                        term_r <= '0;
                        if (is_bypass(model)) begin
                            decayed_potential <= potential_in;
                            done              <= 1'b1;
                            busy              <= 1'b0;
                            state_r           <= DONE;
                        end else begin
                            mask_r  <= (model == MODEL_QLIF) ? cfg_r[4 +: NUM_TERMS]
                                                             : cfg_r[0 +: NUM_TERMS];
                            busy    <= 1'b1;
                            state_r <= ACC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ACC: begin
                    acc_r <= acc_next_s;
                    // Result is written on the edge into DONE so it aligns with the done pulse.
                    if (term_r == LAST_TERM) begin
                        decayed_potential <= result_s;
                        done              <= 1'b1;
                        busy              <= 1'b0;
                        state_r           <= DONE;
                    end else begin
                        term_r <= term_r + TERM_W'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_potential_decay.sv
// Randomized and directed bench for potential_decay against a behavioural model.
module tb_potential_decay;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               time_step = 1'b0;
    logic signed [31:0] potential_in = '0;
    logic        [1:0]  model = 2'b00;
    logic               load = 1'b0;
    logic        [7:0]  decay_cfg = 8'h00;
    logic signed [31:0] decayed_potential;
    logic               done;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DECAY_LEAK_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    potential_decay dut (
        .clk               (clk),
        .rst               (rst),
        .time_step         (time_step),
        .potential_in      (potential_in),
        .model             (model),
        .load              (load),
        .decay_cfg         (decay_cfg),
        .decayed_potential (decayed_potential),
        .done              (done),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // floor(v / 2^k) by plain division with correction toward minus infinity
    function automatic longint fdiv(input longint v, input int k);
        longint d, q;
        d = longint'(1) << k;
        q = v / d;
        if (v < 0 && q * d != v) q = q - 1;
        return q;
    endfunction

    function automatic longint exp_decay(input longint v, input logic [3:0] mask,
                                         input bit bypass);
        longint r;
        r = v;
        if (!bypass) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) r = r - fdiv(v, i + 1);
            if (FLOOR_EN && r > -4 && r < 4) r = 0;
        end
        return r;
    endfunction

    // Behavioural model: cycles-left counter plus pending result.
    logic [7:0] m_cfg;
    int         m_left;
    bit         m_done;
    longint     m_out, m_pending;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cfg = 8'h12; m_left = 0; m_done = 0; m_out = 0; m_pending = 0;
        end else begin
            bit byp;
            logic [3:0] msk;
            if (m_done) begin
                m_done = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_done = 1; m_out = m_pending; end
            end else if (time_step) begin
                byp = (model == 2'b01) || (model == 2'b11);
                msk = (model == 2'b10) ? m_cfg[7:4] : m_cfg[3:0];
                m_pending = exp_decay(longint'(potential_in), msk, byp);
                if (byp) begin m_done = 1; m_out = m_pending; end
                else m_left = 4;
            end
            if (load) m_cfg = decay_cfg;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        check("done", {63'd0, done}, {63'd0, m_done});
        check("busy", {63'd0, busy}, (m_left > 0) ? 64'sd1 : 64'sd0);
        check("decayed_potential", 64'(decayed_potential), m_out);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [7:0] cfg);
        load = 1'b1; decay_cfg = cfg;
        tick();
        load = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] m, input int v,
                          input int exp_val, input int exp_lat);
        int lat, bcnt;
        model = m; potential_in = v; time_step = 1'b1;
        tick();
        time_step = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 10) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within 10 cycles", name);
        end else begin
            check({name, "_latency"}, 64'(lat), 64'(exp_lat));
            check({name, "_busy_cycles"}, 64'(bcnt), 64'((exp_lat == 5) ? 4 : 0));
            check({name, "_value"}, 64'(decayed_potential), 64'(exp_val));
        end
        tick();
    endtask

    initial begin
        int dones;
        #1 rst = 1'b1;
        #1;
        check("reset_value", 64'(decayed_potential), 64'sd0);
        check("reset_done", {63'd0, done}, 64'sd0);
        check("reset_busy", {63'd0, busy}, 64'sd0);
        check("model_pin_lif", exp_decay(100, 4'b0010, 0), 75);
        check("model_pin_neg", exp_decay(-100, 4'b0010, 0), -75);
        check("model_pin_minus1", exp_decay(-1, 4'b0001, 0), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        run_op("lif_default", 2'b00, 100, 75, 5);
        run_op("qlif_default", 2'b10, 100, 50, 5);
        do_load(8'h0F);
        run_op("lif_mask_f", 2'b00, 160, 10, 5);
        run_op("izh_bypass", 2'b01, 35, 35, 1);
        run_op("rsvd_bypass", 2'b11, -7, -7, 1);
        do_load(8'h02);
        run_op("lif_negative", 2'b00, -100, -75, 5);
        do_load(8'h01);
        run_op("lif_minus1", 2'b00, -1, 0, 5);
        do_load(8'h00);
        run_op("lif_mask0", 2'b00, 123, 123, 5);

        // time_step re-pulse and load during an op
        do_load(8'h12);
        model = 2'b00; potential_in = 100; time_step = 1'b1;
        tick();
        time_step = 1'b0;
        tick();
        time_step = 1'b1; load = 1'b1; decay_cfg = 8'hF1;
        tick();
        time_step = 1'b0; load = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                dones++;
                check("hazard_value", 64'(decayed_potential), 64'sd75);
            end
            tick();
        end
        check("hazard_single_done", 64'(dones), 64'sd1);
        run_op("after_load_f1", 2'b00, 100, 50, 5);

        // reset in the middle of an op
        model = 2'b00; potential_in = 100; time_step = 1'b1;
        tick();
        time_step = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("midrst_value", 64'(decayed_potential), 64'sd0);
        check("midrst_done", {63'd0, done}, 64'sd0);
        check("midrst_busy", {63'd0, busy}, 64'sd0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            tick();
        end
        check("midrst_no_done", 64'(dones), 64'sd0);
        run_op("cfg_after_reset", 2'b00, 100, 75, 5);

`ifdef DECAY_LEAK_FLOOR_EN
        do_load(8'h01);
        run_op("floor_small", 2'b00, 6, 0, 5);
        run_op("floor_above", 2'b00, 10, 5, 5);
        run_op("floor_bypass", 2'b01, 2, 2, 1);
`endif

        // randomized traffic; the every-cycle compare does the checking
        for (int c = 0; c < 3000; c++) begin
            time_step = ($urandom_range(0, 3) == 0);
            model     = 2'($urandom_range(0, 3));
            load      = ($urandom_range(0, 15) == 0);
            decay_cfg = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       potential_in = 32'sh8000_0000;
                1:       potential_in = 32'sh7FFF_FFFF;
                2:       potential_in = 32'($urandom_range(0, 15)) - 32'sd8;
                default: potential_in = 32'($urandom);
            endcase
            tick();
        end
        time_step = 1'b0; load = 1'b0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
